// File: rtl/axi_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// axi_sram_responder_pkg
// Shared encodings for the AXI4 SRAM responder: FSM states, AXI response and
// burst codes, word-offset constant, and a helper that ranks responses.
// -----------------------------------------------------------------------------
package axi_sram_responder_pkg;

    // Byte-offset bits inside one 64-bit memory word
    localparam int ADDR_LSB = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_LAT  = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_WR_RESP = 3'd4
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // The used codes are ordered by severity, so the worst is the larger one.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_sram_responder_burst_addr.sv
// -----------------------------------------------------------------------------
// axi_resp_burst_addr
// Combinational per-beat calculator shared by the read and write paths.
//   addr_i, len_i, size_i, burst_i, beat_i : current burst context
//   next_addr_o : address of the following beat (INCR steps, FIXED holds)
//   last_o      : beat_i == len_i
//   resp_o      : per-beat response (SLVERR bad burst/size, DECERR out of range)
//   idx_o       : memory word index for addr_i
// -----------------------------------------------------------------------------
module axi_resp_burst_addr
    import axi_sram_responder_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    IDX_W      = $clog2(DEPTH)
) (
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [7:0]            len_i,
    input  logic [2:0]            size_i,
    input  logic [1:0]            burst_i,
    input  logic [7:0]            beat_i,
    output logic [DATA_WIDTH-1:0] next_addr_o,
    output logic                  last_o,
    output logic [1:0]            resp_o,
    output logic [IDX_W-1:0]      idx_o
);

    localparam logic [DATA_WIDTH:0] SPAN = (DATA_WIDTH+1)'(DEPTH) << ADDR_LSB;

    logic [DATA_WIDTH-1:0] off;
    logic                  in_range;
    logic                  bad_burst;

    assign off       = addr_i - BASE_ADDR;
    // Both bounds checked so addresses below the base never alias via wrap.
    assign in_range  = (addr_i >= BASE_ADDR) && ({1'b0, off} < SPAN);
    assign bad_burst = (burst_i != BURST_FIXED && burst_i != BURST_INCR) || (size_i > 3'd3);

    assign idx_o  = off[ADDR_LSB +: IDX_W];
    assign last_o = (beat_i == len_i);

    always_comb begin
        next_addr_o = addr_i;
        if (burst_i == BURST_INCR)
            next_addr_o = addr_i + (DATA_WIDTH'(1) << size_i);
    end

    always_comb begin
        resp_o = RESP_OKAY;
        if (bad_burst)
            resp_o = RESP_SLVERR;
        else if (!in_range)
            resp_o = RESP_DECERR;
    end

endmodule

// File: rtl/axi_sram_responder.sv
// -----------------------------------------------------------------------------
// axi_sram_responder
// AXI4 subordinate backed by a DEPTH x 64-bit register array. One transaction
// in flight; FIXED/INCR bursts; READ_LATENCY extra cycles before first rvalid.
// Ports:
//   clock, reset (async, active high)
//   AW: awvalid/awready, awaddr, awid, awlen, awsize, awburst
//   W : wvalid/wready, wdata, wstrb, wlast
//   B : bvalid/bready, bresp, bid
//   AR: arvalid/arready, araddr, arid, arlen, arsize, arburst
//   R : rvalid/rready, rdata, rresp, rlast, rid
// Build option: define AXI_RESP_LFSR_DELAY_EN to inject pseudo-random stalls
// on the ready signals and on raising rvalid/bvalid.
// -----------------------------------------------------------------------------
module axi_sram_responder
    import axi_sram_responder_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    DEPTH        = 1024,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h8000_0000,
    parameter int                    READ_LATENCY = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     awaddr,
    input  logic [3:0]                awid,
    input  logic [7:0]                awlen,
    input  logic [2:0]                awsize,
    input  logic [1:0]                awburst,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [2*DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/4-1:0]   wstrb,
    input  logic                      wlast,
    output logic                      bvalid,
    input  logic                      bready,
    output logic [1:0]                bresp,
    output logic [3:0]                bid,
    input  logic                      arvalid,
    output logic                      arready,
    input  logic [DATA_WIDTH-1:0]     araddr,
    input  logic [3:0]                arid,
    input  logic [7:0]                arlen,
    input  logic [2:0]                arsize,
    input  logic [1:0]                arburst,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [2*DATA_WIDTH-1:0]   rdata,
    output logic [1:0]                rresp,
    output logic                      rlast,
    output logic [3:0]                rid
);

    localparam int DW    = 2 * DATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam int IDX_W = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    state_e                state_q;
    logic                  rdy_ok_q;   // low until the first edge after reset
    logic                  prio_rd_q;
    logic [3:0]            id_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [7:0]            beat_q;
    logic [3:0]            lat_q;
    logic [1:0]            wresp_q;
    logic                  wready_q;
    logic                  rvalid_q;
    logic [DW-1:0]         rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;
    logic [3:0]            rid_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic [3:0]            bid_q;

    logic                  stall;
    logic                  ar_hs, aw_hs, w_hs, r_load, mem_we;
    logic [DATA_WIDTH-1:0] b_next;
    logic                  b_last;
    logic [1:0]            b_resp;
    logic [1:0]            w_beat_resp;
    logic [IDX_W-1:0]      b_idx;

`ifdef AXI_RESP_LFSR_DELAY_EN
    // x^16+x^14+x^13+x^11 Fibonacci LFSR, shifting right
    logic [15:0] lfsr_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            lfsr_q <= 16'hACE1;
        else
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    axi_resp_burst_addr #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_W      (IDX_W)
    ) u_calc (
        .addr_i      (addr_q),
        .len_i       (len_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .beat_i      (beat_q),
        .next_addr_o (b_next),
        .last_o      (b_last),
        .resp_o      (b_resp),
        .idx_o       (b_idx)
    );

    // Ready on one address channel only when the other is idle or loses priority.
    assign arready = (state_q == ST_IDLE) && rdy_ok_q && !stall && (!awvalid || prio_rd_q);
    assign awready = (state_q == ST_IDLE) && rdy_ok_q && !stall && (!arvalid || !prio_rd_q);
    assign wready  = wready_q && !stall;

    assign ar_hs = arvalid && arready;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // A beat is loaded into the R registers when none is showing yet, or when
    // the showing non-last beat handshakes (back-to-back, no bubble).
    assign r_load = (state_q == ST_RD_DATA) &&
                    ((!rvalid_q && !stall) || (rvalid_q && rready && !rlast_q));

    // wlast disagreeing with the beat count marks the burst as malformed.
    assign w_beat_resp = (wlast != b_last) ? resp_max(b_resp, RESP_SLVERR) : b_resp;

    assign mem_we = (state_q == ST_WR_DATA) && w_hs && (b_resp == RESP_OKAY);

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;
    assign rlast  = rlast_q;
    assign rid    = rid_q;
    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;
    assign bid    = bid_q;

    // Memory contents survive reset, so the array has its own un-reset process.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < SW; i++) begin
                if (wstrb[i])
                    mem[b_idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rdy_ok_q  <= 1'b0;
            prio_rd_q <= 1'b1;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            wresp_q   <= RESP_OKAY;
            wready_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
        end else begin
            rdy_ok_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (ar_hs) begin
                        prio_rd_q <= 1'b0;
                        id_q      <= arid;
                        addr_q    <= araddr;
                        len_q     <= arlen;
                        size_q    <= arsize;
                        burst_q   <= arburst;
                        beat_q    <= '0;
                        if (READ_LATENCY == 0) begin
                            state_q <= ST_RD_DATA;
                        end else begin
                            lat_q   <= 4'(READ_LATENCY - 1);
                            state_q <= ST_RD_LAT;
                        end
                    end else if (aw_hs) begin
                        prio_rd_q <= 1'b1;
                        id_q      <= awid;
                        addr_q    <= awaddr;
                        len_q     <= awlen;
                        size_q    <= awsize;
                        burst_q   <= awburst;
                        beat_q    <= '0;
                        wresp_q   <= RESP_OKAY;
                        wready_q  <= 1'b1;
                        state_q   <= ST_WR_DATA;
                    end
                end

                ST_RD_LAT: begin
                    if (lat_q == 4'd0)
                        state_q <= ST_RD_DATA;
                    else
                        lat_q <= lat_q - 4'd1;
                end

                ST_RD_DATA: begin
                    if (r_load) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= (b_resp == RESP_OKAY) ? mem[b_idx] : '0;
                        rresp_q  <= b_resp;
                        rlast_q  <= b_last;
                        rid_q    <= id_q;
                        addr_q   <= b_next;
                        beat_q   <= beat_q + 8'd1;
                    end else if (rvalid_q && rready) begin
                        // last beat accepted
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end

                ST_WR_DATA: begin
                    if (w_hs) begin
                        wresp_q <= resp_max(wresp_q, w_beat_resp);
                        if (wlast || b_last) begin
                            wready_q <= 1'b0;
                            state_q  <= ST_WR_RESP;
                        end else begin
                            addr_q <= b_next;
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end

                ST_WR_RESP: begin
                    if (!bvalid_q) begin
                        if (!stall) begin
                            bvalid_q <= 1'b1;
                            bresp_q  <= wresp_q;
                            bid_q    <= id_q;
                        end
                    end else if (bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_responder.sv
module tb_axi_sram_responder;

    localparam int BOUND = 200;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] awaddr, araddr;
    logic [3:0]  awid, arid, bid, rid;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [63:0] wdata, rdata;
    logic        arvalid, arready, rvalid, rready, rlast;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rd_exp_t;

    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } wr_exp_t;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    int      checks = 0;
    int      errors = 0;
    bit      rr_mode = 1'b0;

    axi_sram_responder dut (
        .clock   (clock),   .reset   (reset),
        .awvalid (awvalid), .awready (awready), .awaddr (awaddr), .awid (awid),
        .awlen   (awlen),   .awsize  (awsize),  .awburst (awburst),
        .wvalid  (wvalid),  .wready  (wready),  .wdata  (wdata),  .wstrb (wstrb),
        .wlast   (wlast),
        .bvalid  (bvalid),  .bready  (bready),  .bresp  (bresp),  .bid   (bid),
        .arvalid (arvalid), .arready (arready), .araddr (araddr), .arid  (arid),
        .arlen   (arlen),   .arsize  (arsize),  .arburst (arburst),
        .rvalid  (rvalid),  .rready  (rready),  .rdata  (rdata),  .rresp (rresp),
        .rlast   (rlast),   .rid     (rid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected handshake", nm);
    endtask

    // rready: held high, or high one cycle in three when rr_mode is set
    initial begin
        int cyc = 0;
        rready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            rready = !rr_mode || (cyc % 3 == 0);
        end
    end

    // Monitor: pops expectations on every R/B handshake, checks R hold under stall
    initial begin
        bit          pstall = 1'b0;
        logic [63:0] pdata;
        logic [1:0]  presp;
        logic        plast;
        logic [3:0]  pid;
        rd_exp_t     re;
        wr_exp_t     we;
        forever begin
            @(negedge clock);
            if (reset) begin
                pstall = 1'b0;
            end else begin
                if (pstall) begin
                    chk("r_hold_valid", 64'(rvalid), 64'd1);
                    chk("r_hold_data", rdata, pdata);
                    chk("r_hold_resp", 64'(rresp), 64'(presp));
                    chk("r_hold_last", 64'(rlast), 64'(plast));
                    chk("r_hold_id", 64'(rid), 64'(pid));
                end
                pstall = rvalid && !rready;
                pdata = rdata; presp = rresp; plast = rlast; pid = rid;
                if (rvalid && rready) begin
                    if (rd_q.size() == 0) begin
                        tmo("unexpected_r_beat");
                    end else begin
                        re = rd_q.pop_front();
                        chk("rdata", rdata, re.data);
                        chk("rresp", 64'(rresp), 64'(re.resp));
                        chk("rlast", 64'(rlast), 64'(re.last));
                        chk("rid", 64'(rid), 64'(re.id));
                    end
                end
                if (bvalid && bready) begin
                    if (wr_q.size() == 0) begin
                        tmo("unexpected_b");
                    end else begin
                        we = wr_q.pop_front();
                        chk("bresp", 64'(bresp), 64'(we.resp));
                        chk("bid", 64'(bid), 64'(we.id));
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((rd_q.size() != 0 || wr_q.size() != 0 || rvalid || bvalid) && n < BOUND) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (rd_q.size() != 0 || wr_q.size() != 0 || rvalid || bvalid) begin
            tmo("idle_wait");
            rd_q.delete();
            wr_q.delete();
        end
    endtask

    task automatic ar_handshake(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                                input logic [1:0] burst, input bit chk_lat);
        int n = 0;
        araddr = a; arid = id; arlen = len; arburst = burst; arsize = 3'd3; arvalid = 1'b1;
        do begin @(negedge clock); n++; end while (!arready && n < BOUND);
        if (!arready) tmo("ar_wait");
        @(posedge clock);
        #1;
        arvalid = 1'b0;
        if (chk_lat) begin
            n = 0;
            while (!rvalid && n < 20) begin @(posedge clock); #1; n++; end
            chk("rd_first_latency", 64'(n), 64'd2);
        end
    endtask

    task automatic rd_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input logic [63:0] d0, input logic [63:0] step,
                            input logic [1:0] resp, input bit chk_lat);
        for (int i = 0; i <= int'(len); i++)
            rd_q.push_back('{d0 + step * 64'(i), resp, (i == int'(len)), id});
        ar_handshake(a, id, len, burst, chk_lat);
        wait_idle();
    endtask

    task automatic aw_set(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst);
        awaddr = a; awid = id; awlen = len; awburst = burst; awsize = 3'd3; awvalid = 1'b1;
    endtask

    task automatic w_beats(input logic [63:0] d0, input logic [7:0] strb, input int nbeats);
        int n;
        for (int i = 0; i < nbeats; i++) begin
            wdata = d0 + 64'(i); wstrb = strb; wlast = (i == nbeats - 1); wvalid = 1'b1;
            n = 0;
            do begin @(negedge clock); n++; end while (!wready && n < BOUND);
            if (!wready) tmo("w_wait");
            @(posedge clock);
            #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic wr_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input logic [63:0] d0, input logic [7:0] strb,
                            input int nbeats, input logic [1:0] resp);
        int n = 0;
        wr_q.push_back('{resp, id});
        aw_set(a, id, len, burst);
        do begin @(negedge clock); n++; end while (!awready && n < BOUND);
        if (!awready) tmo("aw_wait");
        @(posedge clock);
        #1;
        awvalid = 1'b0;
        w_beats(d0, strb, nbeats);
        wait_idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1'b1; wlast = 0;
        awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
        araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0;
        wdata = 0; wstrb = 0;

        // reset values and ready release timing
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_rlast", 64'(rlast), 64'd0);
        chk("rst_bresp_bid", 64'({bresp, bid, rresp, rid}), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("arready_before_edge", 64'(arready), 64'd0);
        chk("awready_before_edge", 64'(awready), 64'd0);
        @(posedge clock);
        #1;
        chk("arready_after_edge", 64'(arready), 64'd1);
        chk("awready_after_edge", 64'(awready), 64'd1);

        // single write, read back with latency check
        wr_burst(32'h8000_0010, 4'd3, 8'd0, 2'b01, 64'h1122334455667788, 8'hFF, 1, 2'b00);
        rd_burst(32'h8000_0010, 4'd5, 8'd0, 2'b01, 64'h1122334455667788, 64'd0, 2'b00, 1'b1);

        // 4-beat INCR write then read, rready held, then rready toggling
        wr_burst(32'h8000_0000, 4'd1, 8'd3, 2'b01, 64'hA5A5_0000_0000_0000, 8'hFF, 4, 2'b00);
        rd_burst(32'h8000_0000, 4'd2, 8'd3, 2'b01, 64'hA5A5_0000_0000_0000, 64'd1, 2'b00, 1'b0);
        rr_mode = 1'b1;
        rd_burst(32'h8000_0000, 4'd6, 8'd3, 2'b01, 64'hA5A5_0000_0000_0000, 64'd1, 2'b00, 1'b0);
        rr_mode = 1'b0;
        @(posedge clock);
        #1;

        // partial strobe merge
        wr_burst(32'h8000_0100, 4'd4, 8'd0, 2'b01, 64'h1111111111111111, 8'hFF, 1, 2'b00);
        wr_burst(32'h8000_0100, 4'd4, 8'd0, 2'b01, 64'hFFFFFFFF_AAAAAAAA, 8'h0F, 1, 2'b00);
        rd_burst(32'h8000_0100, 4'd8, 8'd0, 2'b01, 64'h11111111_AAAAAAAA, 64'd0, 2'b00, 1'b0);

        // FIXED read repeats the same word
        rd_burst(32'h8000_0100, 4'd7, 8'd1, 2'b00, 64'h11111111_AAAAAAAA, 64'd0, 2'b00, 1'b0);

        // arbitration: read wins first after reset, then write
        do_reset();
        aw_set(32'h8000_0108, 4'd9, 8'd0, 2'b01);
        araddr = 32'h8000_0100; arid = 4'd10; arlen = 0; arburst = 2'b01; arsize = 3'd3; arvalid = 1'b1;
        @(negedge clock);
        chk("arb1_arready", 64'(arready), 64'd1);
        chk("arb1_awready", 64'(awready), 64'd0);
        rd_q.push_back('{64'h11111111_AAAAAAAA, 2'b00, 1'b1, 4'd10});
        @(posedge clock);
        #1;
        arvalid = 1'b0;
        awvalid = 1'b0;
        wait_idle();
        aw_set(32'h8000_0108, 4'd11, 8'd0, 2'b01);
        araddr = 32'h8000_0108; arid = 4'd12; arvalid = 1'b1;
        @(negedge clock);
        chk("arb2_awready", 64'(awready), 64'd1);
        chk("arb2_arready", 64'(arready), 64'd0);
        wr_q.push_back('{2'b00, 4'd11});
        rd_q.push_back('{64'h0123456789ABCDEF, 2'b00, 1'b1, 4'd12});
        @(posedge clock);
        #1;
        awvalid = 1'b0;
        w_beats(64'h0123456789ABCDEF, 8'hFF, 1);
        ar_handshake(32'h8000_0108, 4'd12, 8'd0, 2'b01, 1'b0);
        wait_idle();

        // errors: below base, WRAP write, wlast before len
        rd_burst(32'h7FFF_FFF8, 4'd13, 8'd0, 2'b01, 64'd0, 64'd0, 2'b11, 1'b0);
        wr_burst(32'h8000_0100, 4'd14, 8'd0, 2'b10, 64'hDEADBEEF_DEADBEEF, 8'hFF, 1, 2'b10);
        rd_burst(32'h8000_0100, 4'd15, 8'd0, 2'b01, 64'h11111111_AAAAAAAA, 64'd0, 2'b00, 1'b0);
        wr_burst(32'h8000_0200, 4'd2, 8'd1, 2'b01, 64'h5555, 8'hFF, 1, 2'b10);
        rd_burst(32'h8000_2000, 4'd3, 8'd0, 2'b01, 64'd0, 64'd0, 2'b11, 1'b0);

        // async reset in the middle of a 4-beat read
        for (int i = 0; i < 4; i++)
            rd_q.push_back('{64'hA5A5_0000_0000_0000 + 64'(i), 2'b00, (i == 3), 4'd1});
        ar_handshake(32'h8000_0000, 4'd1, 8'd3, 2'b01, 1'b0);
        n = 0;
        while (rd_q.size() > 2 && n < BOUND) begin @(posedge clock); #1; n++; end
        if (rd_q.size() > 2) tmo("beat2_wait");
        chk("mid_rvalid_before_reset", 64'(rvalid), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_rvalid", 64'(rvalid), 64'd0);
        chk("async_rst_rlast", 64'(rlast), 64'd0);
        chk("async_rst_rdata", rdata, 64'd0);
        chk("async_rst_arready", 64'(arready), 64'd0);
        rd_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_arready_early", 64'(arready), 64'd0);
        @(posedge clock);
        #1;
        chk("post_rst_arready", 64'(arready), 64'd1);
        rd_burst(32'h8000_0018, 4'd4, 8'd0, 2'b01, 64'hA5A5_0000_0000_0003, 64'd0, 2'b00, 1'b1);

        wait_idle();
        chk("rd_queue_drained", 64'(rd_q.size()), 64'd0);
        chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule
